// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory-bus master between the I-cache
// (read refills) and the D-cache (refills and write-backs). Grants are
// non-preemptive and held until the bus completion arrives. A round-robin bit
// keeps either cache from starving the other.
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_icache_start_read,
    input  logic [ADDR_WIDTH-1:0] i_icache_addr,
    input  logic                  i_dcache_start_read,
    input  logic                  i_dcache_start_write,
    input  logic [ADDR_WIDTH-1:0] i_dcache_addr,
    input  logic                  i_r_last,
    input  logic                  i_b_resp,
    output logic                  o_start_read,
    output logic                  o_start_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_icache_r_last,
    output logic                  o_dcache_r_last,
    output logic                  o_dcache_b_resp,
    output logic                  o_grant_icache,
    output logic                  o_grant_dcache
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_READ  = 2'd1,
        D_READ  = 2'd2,
        D_WRITE = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   prefer_d_reg;
    logic   prefer_d_next;

    logic   d_req;
    state_t d_target;

    // The D-cache write-back always goes before its allocate read.
    assign d_req    = i_dcache_start_read | i_dcache_start_write;
    assign d_target = i_dcache_start_write ? D_WRITE : D_READ;

    // State and fairness registers. arst abandons any grant at once.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg    <= IDLE;
            prefer_d_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prefer_d_reg <= prefer_d_next;
        end
    end

    // Arbitration, completion routing and bus steering, all taken from the current state.
    always_comb begin
        state_next      = state_reg;
        prefer_d_next   = prefer_d_reg;
        o_start_read    = 1'b0;
        o_start_write   = 1'b0;
        o_mem_addr      = i_dcache_addr;
        o_icache_r_last = 1'b0;
        o_dcache_r_last = 1'b0;
        o_dcache_b_resp = 1'b0;
        o_grant_icache  = 1'b0;
        o_grant_dcache  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_icache_start_read && d_req) begin
                    state_next = prefer_d_reg ? d_target : I_READ;
                end else if (i_icache_start_read) begin
                    state_next = I_READ;
                end else if (d_req) begin
                    state_next = d_target;
                end
            end
            I_READ: begin
                o_start_read    = 1'b1;
                o_grant_icache  = 1'b1;
                o_mem_addr      = i_icache_addr;
                o_icache_r_last = i_r_last;
                if (i_r_last) begin
                    state_next    = IDLE;
                    prefer_d_next = 1'b1;
                end
            end
            D_READ: begin
                o_start_read    = 1'b1;
                o_grant_dcache  = 1'b1;
                o_dcache_r_last = i_r_last;
                if (i_r_last) begin
                    state_next    = IDLE;
                    prefer_d_next = 1'b0;
                end
            end
            D_WRITE: begin
                o_start_write   = 1'b1;
                o_grant_dcache  = 1'b1;
                o_dcache_b_resp = i_b_resp;
                if (i_b_resp) begin
                    state_next    = IDLE;
                    prefer_d_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Testbench for cache_mem_arbiter. It drives directed vectors and checks them
// with hand-computed literals. A separate model tracks who owns the bus, and
// every cycle's outputs are compared against that model.
module tb_cache_mem_arbiter;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          arst;
    logic          icache_start_read;
    logic [AW-1:0] icache_addr;
    logic          dcache_start_read;
    logic          dcache_start_write;
    logic [AW-1:0] dcache_addr;
    logic          r_last;
    logic          b_resp;
    logic          start_read;
    logic          start_write;
    logic [AW-1:0] mem_addr;
    logic          icache_r_last;
    logic          dcache_r_last;
    logic          dcache_b_resp;
    logic          grant_icache;
    logic          grant_dcache;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .arst                (arst),
        .i_icache_start_read (icache_start_read),
        .i_icache_addr       (icache_addr),
        .i_dcache_start_read (dcache_start_read),
        .i_dcache_start_write(dcache_start_write),
        .i_dcache_addr       (dcache_addr),
        .i_r_last            (r_last),
        .i_b_resp            (b_resp),
        .o_start_read        (start_read),
        .o_start_write       (start_write),
        .o_mem_addr          (mem_addr),
        .o_icache_r_last     (icache_r_last),
        .o_dcache_r_last     (dcache_r_last),
        .o_dcache_b_resp     (dcache_b_resp),
        .o_grant_icache      (grant_icache),
        .o_grant_dcache      (grant_dcache)
    );

    // Model: who owns the bus (0 none, 1 I-cache read, 2 D-cache read,
    // 3 D-cache write) and whose turn it is on a tie.
    int   owner = 0;
    logic d_turn = 1'b0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            owner  <= 0;
            d_turn <= 1'b0;
        end else if (owner == 0) begin
            if (icache_start_read && !(d_turn && (dcache_start_read || dcache_start_write)))
                owner <= 1;
            else if (dcache_start_write)
                owner <= 3;
            else if (dcache_start_read)
                owner <= 2;
        end else if ((owner == 1 || owner == 2) && r_last) begin
            owner  <= 0;
            d_turn <= (owner == 1);
        end else if (owner == 3 && b_resp) begin
            owner  <= 0;
            d_turn <= 1'b0;
        end
    end

    // Compare every cycle, on the falling edge, against the model.
    always @(negedge clk) begin
        logic [6:0]    exp_flags;
        logic [6:0]    act_flags;
        logic [AW-1:0] exp_addr;
        exp_flags = {(owner == 1 || owner == 2), (owner == 3),
                     (owner == 1) && r_last, (owner == 2) && r_last,
                     (owner == 3) && b_resp, (owner == 1), (owner >= 2)};
        act_flags = {start_read, start_write, icache_r_last, dcache_r_last,
                     dcache_b_resp, grant_icache, grant_dcache};
        exp_addr  = (owner == 1) ? icache_addr : dcache_addr;
        checks++;
        if (act_flags !== exp_flags) begin
            errors++;
            $display("FAIL model_flags t=%0t got %b expected %b", $time, act_flags, exp_flags);
        end
        checks++;
        if (mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL model_addr t=%0t got %h expected %h", $time, mem_addr, exp_addr);
        end
    end

    task automatic lit(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
        end else begin
            $display("check %s t=%0t value %h ok", name, $time, act);
        end
    endtask

    // Moves to just after the next rising edge, which is where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        arst = 1'b1;
        repeat (cycles) tick();
        arst = 1'b0;
    endtask

    initial begin
        arst               = 1'b1;
        icache_start_read  = 1'b0;
        icache_addr        = '0;
        dcache_start_read  = 1'b0;
        dcache_start_write = 1'b0;
        dcache_addr        = 64'hD0;
        r_last             = 1'b0;
        b_resp             = 1'b0;

        // Hold reset for 3 cycles with no requests.
        repeat (3) tick();
        #1;
        lit("reset_start_read", {63'd0, start_read}, 64'd0);
        lit("reset_grants", {62'd0, grant_icache, grant_dcache}, 64'd0);
        lit("reset_addr", mem_addr, 64'hD0);
        arst = 1'b0;
        tick();
        #1;
        lit("idle_addr", mem_addr, 64'hD0);

        // Single I-cache refill.
        icache_addr       = 64'h1000;
        icache_start_read = 1'b1;
        #1;
        lit("i_req_not_yet", {63'd0, grant_icache}, 64'd0);
        tick();
        #1;
        lit("i_grant", {61'd0, start_read, grant_icache, grant_dcache}, 64'b110);
        lit("i_addr", mem_addr, 64'h1000);
        icache_start_read = 1'b0;      // dropping the request mid-grant must not release the bus
        tick();
        #1;
        lit("i_held", {63'd0, grant_icache}, 64'd1);
        r_last = 1'b1;
        #1;
        lit("i_r_last_fwd", {62'd0, icache_r_last, dcache_r_last}, 64'b10);
        tick();
        r_last = 1'b0;
        #1;
        lit("i_back_idle", {62'd0, grant_icache, start_read}, 64'd0);

        // Reset again so that the tie starts with the I-cache favoured.
        do_reset(1);
        icache_addr       = 64'h1000;
        dcache_addr       = 64'h2000;
        icache_start_read = 1'b1;
        dcache_start_read = 1'b1;
        tick();
        #1;
        lit("tie_i_first", {62'd0, grant_icache, grant_dcache}, 64'b10);
        r_last = 1'b1;
        tick();
        r_last            = 1'b0;
        icache_start_read = 1'b0;
        #1;
        lit("tie_idle_gap", {62'd0, grant_icache, grant_dcache}, 64'd0);
        tick();
        #1;
        lit("tie_d_second", {62'd0, grant_icache, grant_dcache}, 64'b01);
        lit("tie_d_addr", mem_addr, 64'h2000);
        r_last = 1'b1;
        #1;
        lit("d_r_last_fwd", {62'd0, icache_r_last, dcache_r_last}, 64'b01);
        tick();
        r_last            = 1'b0;
        icache_start_read = 1'b1;
        tick();
        #1;
        lit("tie_again_i", {62'd0, grant_icache, grant_dcache}, 64'b10);
        lit("tie_again_addr", mem_addr, 64'h1000);
        r_last = 1'b1;
        tick();
        r_last            = 1'b0;
        icache_start_read = 1'b0;
        dcache_start_read = 1'b0;
        tick();

        // D-cache dirty miss: the write-back wins over the read that arrives with it.
        dcache_addr        = 64'h3000;
        dcache_start_write = 1'b1;
        dcache_start_read  = 1'b1;
        tick();
        #1;
        lit("dw_start", {61'd0, start_read, start_write, grant_dcache}, 64'b011);
        r_last = 1'b1;                 // stray read completion during a write
        #1;
        lit("dw_stray_r_last", {62'd0, icache_r_last, dcache_r_last}, 64'd0);
        tick();
        r_last = 1'b0;
        #1;
        lit("dw_still_held", {62'd0, start_write, grant_dcache}, 64'b11);
        b_resp = 1'b1;
        #1;
        lit("dw_b_resp_fwd", {63'd0, dcache_b_resp}, 64'd1);
        tick();
        b_resp             = 1'b0;
        dcache_start_write = 1'b0;
        #1;
        lit("dw_idle", {62'd0, start_write, grant_dcache}, 64'd0);
        tick();
        #1;
        lit("dr_after_wb", {61'd0, start_read, start_write, grant_dcache}, 64'b101);

        // Asynchronous reset during D_READ drops everything at once.
        #2;
        arst = 1'b1;
        #1;
        lit("arst_drop", {61'd0, start_read, grant_icache, grant_dcache}, 64'd0);
        lit("arst_addr", mem_addr, 64'h3000);
        tick();
        arst              = 1'b0;
        icache_start_read = 1'b1;
        icache_addr       = 64'h4000;
        tick();
        #1;
        lit("post_arst_tie_i", {62'd0, grant_icache, grant_dcache}, 64'b10);
        b_resp = 1'b1;                 // stray write response during an I-cache read
        #1;
        lit("i_stray_b_resp", {63'd0, dcache_b_resp}, 64'd0);
        tick();
        b_resp = 1'b0;
        #1;
        lit("i_still_held", {63'd0, grant_icache}, 64'd1);
        r_last = 1'b1;
        tick();
        r_last            = 1'b0;
        icache_start_read = 1'b0;
        dcache_start_read = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
